// File: rtl/sfm_row_scheduler.sv
// sfm_row_scheduler: batch-level sequencer for the two-pass softmax flow.
// Runs ACC -> WAIT -> DIV once per row over n_rows rows, stepping the input
// and output base addresses by row_stride between rows, and issues the
// streamer req_start pulses. One start_i launches a whole batch.
// Optional feature: define SFM_ROW_SCHED_PERF_EN to build the saturating
// busy-cycle counter on cycles_o; otherwise cycles_o is tied to 0.
module sfm_row_scheduler #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 32,
  parameter int unsigned ROW_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] in_base_i,
  input  logic [ADDR_WIDTH-1:0] out_base_i,
  input  logic [ADDR_WIDTH-1:0] row_stride_i,
  input  logic [LEN_WIDTH-1:0]  row_len_i,
  input  logic [ROW_WIDTH-1:0]  n_rows_i,
  input  logic                  in_done_i,
  input  logic                  out_done_i,
  input  logic                  reducing_i,
  output logic                  in_start_o,
  output logic                  out_start_o,
  output logic [ADDR_WIDTH-1:0] in_addr_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic [LEN_WIDTH-1:0]  tot_len_o,
  output logic                  acc_finished_o,
  output logic                  dividing_o,
  output logic [ROW_WIDTH-1:0]  row_idx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           cycles_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_WAIT,
    S_DIV,
    S_NEXT
  } state_e;

  state_e                state_q;
  logic                  in_start_q;
  logic                  out_start_q;
  logic [ADDR_WIDTH-1:0] in_addr_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]  tot_len_q;
  logic [ROW_WIDTH-1:0]  n_rows_q;
  logic [ROW_WIDTH-1:0]  row_idx_q;
  logic                  acc_finished_q;
  logic                  dividing_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  last_row;

  assign last_row = (row_idx_q == (n_rows_q - ROW_WIDTH'(1)));

  // Row sequencer FSM; all outputs are registered alongside the state.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      in_start_q     <= 1'b0;
      out_start_q    <= 1'b0;
      in_addr_q      <= '0;
      out_addr_q     <= '0;
      stride_q       <= '0;
      tot_len_q      <= '0;
      n_rows_q       <= '0;
      row_idx_q      <= '0;
      acc_finished_q <= 1'b0;
      dividing_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else if (clear_i) begin
      state_q        <= S_IDLE;
      in_start_q     <= 1'b0;
      out_start_q    <= 1'b0;
      in_addr_q      <= '0;
      out_addr_q     <= '0;
      stride_q       <= '0;
      tot_len_q      <= '0;
      n_rows_q       <= '0;
      row_idx_q      <= '0;
      acc_finished_q <= 1'b0;
      dividing_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      // Pulse outputs default low and are raised only on the cycle needed.
      in_start_q  <= 1'b0;
      out_start_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (n_rows_i != '0) begin
              in_addr_q  <= in_base_i;
              out_addr_q <= out_base_i;
              stride_q   <= row_stride_i;
              tot_len_q  <= row_len_i;
              n_rows_q   <= n_rows_i;
              row_idx_q  <= '0;
              busy_q     <= 1'b1;
              in_start_q <= 1'b1;
              state_q    <= S_ACC;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_ACC: begin
          if (in_done_i) begin
            acc_finished_q <= 1'b1;
            state_q        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (reducing_i) begin
            acc_finished_q <= 1'b0;
            dividing_q     <= 1'b1;
            // Second pass re-reads the row while writing results out.
            in_start_q     <= 1'b1;
            out_start_q    <= 1'b1;
            state_q        <= S_DIV;
          end
        end
        S_DIV: begin
          if (out_done_i) begin
            dividing_q <= 1'b0;
            if (last_row) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              row_idx_q <= row_idx_q + ROW_WIDTH'(1);
              state_q   <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          // Address wrap past 2^ADDR_WIDTH is intentional and silent.
          in_addr_q  <= in_addr_q + stride_q;
          out_addr_q <= out_addr_q + stride_q;
          in_start_q <= 1'b1;
          state_q    <= S_ACC;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_start_o     = in_start_q;
  assign out_start_o    = out_start_q;
  assign in_addr_o      = in_addr_q;
  assign out_addr_o     = out_addr_q;
  assign tot_len_o      = tot_len_q;
  assign acc_finished_o = acc_finished_q;
  assign dividing_o     = dividing_q;
  assign row_idx_o      = row_idx_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

`ifdef SFM_ROW_SCHED_PERF_EN
  logic [31:0] cycles_q;
  logic [31:0] cycles_d;
  logic        start_accept;

  assign start_accept = (state_q == S_IDLE) && start_i;

  // Next busy-cycle count: restart on a new batch, saturate at all-ones.
  // NOTE: assign a default first so no path leaves cycles_d unassigned
  // (which would infer a latch).
  always_comb begin
    cycles_d = cycles_q;
    if (start_accept) begin
      cycles_d = '0;
    end else if (busy_q && (cycles_q != '1)) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  // Busy-cycle counter register; soft clear and reset both zero it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_q <= '0;
    end else if (clear_i) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles_o = cycles_q;
`else
  assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_sfm_row_scheduler.sv
// Directed self-checking bench for sfm_row_scheduler (default parameters).
// Expected busy-cycle counts depend on whether SFM_ROW_SCHED_PERF_EN is set.
module tb_sfm_row_scheduler;

`ifdef SFM_ROW_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        start_i;
  logic [31:0] in_base_i;
  logic [31:0] out_base_i;
  logic [31:0] row_stride_i;
  logic [31:0] row_len_i;
  logic [15:0] n_rows_i;
  logic        in_done_i;
  logic        out_done_i;
  logic        reducing_i;
  logic        in_start_o;
  logic        out_start_o;
  logic [31:0] in_addr_o;
  logic [31:0] out_addr_o;
  logic [31:0] tot_len_o;
  logic        acc_finished_o;
  logic        dividing_o;
  logic [15:0] row_idx_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] cycles_o;

  int checks = 0;
  int errors = 0;
  int n_in   = 0;
  int n_out  = 0;
  int n_done = 0;
  int n_in0, n_out0, n_done0;

  always #5 clk = ~clk;

  sfm_row_scheduler dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .in_base_i      (in_base_i),
    .out_base_i     (out_base_i),
    .row_stride_i   (row_stride_i),
    .row_len_i      (row_len_i),
    .n_rows_i       (n_rows_i),
    .in_done_i      (in_done_i),
    .out_done_i     (out_done_i),
    .reducing_i     (reducing_i),
    .in_start_o     (in_start_o),
    .out_start_o    (out_start_o),
    .in_addr_o      (in_addr_o),
    .out_addr_o     (out_addr_o),
    .tot_len_o      (tot_len_o),
    .acc_finished_o (acc_finished_o),
    .dividing_o     (dividing_o),
    .row_idx_o      (row_idx_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .cycles_o       (cycles_o)
  );

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (in_start_o)  n_in++;
    if (out_start_o) n_out++;
    if (done_o)      n_done++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_in_done();
    in_done_i = 1'b1; tick(); in_done_i = 1'b0;
  endtask

  task automatic pulse_reducing();
    reducing_i = 1'b1; tick(); reducing_i = 1'b0;
  endtask

  task automatic pulse_out_done();
    out_done_i = 1'b1; tick(); out_done_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    in_base_i = '0; out_base_i = '0; row_stride_i = '0; row_len_i = '0; n_rows_i = '0;
    in_done_i = 1'b0; out_done_i = 1'b0; reducing_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",     32'(busy_o),         32'd0);
    check("rst_done",     32'(done_o),         32'd0);
    check("rst_in_start", 32'(in_start_o),     32'd0);
    check("rst_out_start",32'(out_start_o),    32'd0);
    check("rst_in_addr",  in_addr_o,           32'd0);
    check("rst_out_addr", out_addr_o,          32'd0);
    check("rst_tot_len",  tot_len_o,           32'd0);
    check("rst_row_idx",  32'(row_idx_o),      32'd0);
    check("rst_acc_fin",  32'(acc_finished_o), 32'd0);
    check("rst_div",      32'(dividing_o),     32'd0);
    check("rst_cycles",   cycles_o,            32'd0);
    rst_ni = 1'b1;
    tick();

    // Single row, 10-cycle busy period
    in_base_i = 32'h1000; out_base_i = 32'h2000; row_stride_i = 32'h40;
    row_len_i = 32'h10; n_rows_i = 16'd1;
    start_i = 1'b1; tick(); start_i = 1'b0;                   // c1 ACC
    check("t1_in_start",  32'(in_start_o),  32'd1);
    check("t1_out_start", 32'(out_start_o), 32'd0);
    check("t1_busy",      32'(busy_o),      32'd1);
    check("t1_in_addr",   in_addr_o,        32'h1000);
    check("t1_out_addr",  out_addr_o,       32'h2000);
    check("t1_tot_len",   tot_len_o,        32'h10);
    check("t1_row_idx",   32'(row_idx_o),   32'd0);
    tick();                                                   // c2 ACC
    check("t1_in_start_once", 32'(in_start_o), 32'd0);
    tick();                                                   // c3 ACC
    pulse_in_done();                                          // c4 WAIT
    check("t1_acc_fin",   32'(acc_finished_o), 32'd1);
    check("t1_div_wait",  32'(dividing_o),     32'd0);
    tick();                                                   // c5 WAIT
    check("t1_acc_fin_hold", 32'(acc_finished_o), 32'd1);
    pulse_reducing();                                         // c6 DIV
    check("t1_acc_fin_off",  32'(acc_finished_o), 32'd0);
    check("t1_div",          32'(dividing_o),     32'd1);
    check("t1_div_in_start", 32'(in_start_o),     32'd1);
    check("t1_div_out_start",32'(out_start_o),    32'd1);
    tick();                                                   // c7 DIV
    check("t1_div_in_once",  32'(in_start_o),  32'd0);
    check("t1_div_out_once", 32'(out_start_o), 32'd0);
    check("t1_div_hold",     32'(dividing_o),  32'd1);
    tick(); tick(); tick();                                   // c8..c10 DIV
    pulse_out_done();                                         // c11 IDLE
    check("t1_done",      32'(done_o),     32'd1);
    check("t1_busy_end",  32'(busy_o),     32'd0);
    check("t1_div_end",   32'(dividing_o), 32'd0);
    check("t1_cycles",    cycles_o,        PERF ? 32'd10 : 32'd0);
    tick();
    check("t1_done_pulse", 32'(done_o), 32'd0);
    check("t1_cycles_hold", cycles_o,   PERF ? 32'd10 : 32'd0);

    // Three rows, stride 0x40
    n_in0 = n_in; n_out0 = n_out; n_done0 = n_done;
    n_rows_i = 16'd3;
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("t2_cycles_clr", cycles_o, 32'd0);
    for (int r = 0; r < 3; r++) begin
      if (r != 0) begin
        check("t2_next_row_idx", 32'(row_idx_o), 32'(r));
        check("t2_next_busy",    32'(busy_o),    32'd1);
        check("t2_next_no_start",32'(in_start_o),32'd0);
        tick();
      end
      check("t2_in_addr",  in_addr_o,       32'h1000 + 32'(r) * 32'h40);
      check("t2_out_addr", out_addr_o,      32'h2000 + 32'(r) * 32'h40);
      check("t2_in_start", 32'(in_start_o), 32'd1);
      check("t2_row_idx",  32'(row_idx_o),  32'(r));
      pulse_in_done();
      pulse_reducing();
      pulse_out_done();
    end
    check("t2_done",      32'(done_o), 32'd1);
    check("t2_busy_end",  32'(busy_o), 32'd0);
    check("t2_n_in",      32'(n_in - n_in0),   32'd6);
    check("t2_n_out",     32'(n_out - n_out0), 32'd3);

    // Address wrap; start issued in the done cycle of the previous batch
    in_base_i = 32'hFFFF_FFC0; out_base_i = 32'h2000; n_rows_i = 16'd2;
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("t2_n_done",    32'(n_done - n_done0), 32'd1);
    check("t4_busy",      32'(busy_o),     32'd1);
    check("t4_in_start",  32'(in_start_o), 32'd1);
    check("t4_in_addr0",  in_addr_o,       32'hFFFF_FFC0);
    pulse_in_done();
    pulse_reducing();
    pulse_out_done();
    tick();
    check("t4_in_addr1",  in_addr_o,  32'h0000_0000);
    check("t4_out_addr1", out_addr_o, 32'h2040);
    pulse_in_done();
    pulse_reducing();
    pulse_out_done();
    check("t4_done",      32'(done_o), 32'd1);

    // Zero-row batch
    tick();
    n_in0 = n_in;
    n_rows_i = 16'd0;
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("t3_done",     32'(done_o),     32'd1);
    check("t3_busy",     32'(busy_o),     32'd0);
    check("t3_in_start", 32'(in_start_o), 32'd0);
    tick();
    check("t3_done_off", 32'(done_o), 32'd0);
    check("t3_busy_off", 32'(busy_o), 32'd0);
    check("t3_n_in",     32'(n_in - n_in0), 32'd0);

    // Clear during DIV of row 1 of 3; start while busy ignored
    in_base_i = 32'h1000; out_base_i = 32'h2000; n_rows_i = 16'd3;
    start_i = 1'b1; tick(); start_i = 1'b0;
    in_base_i = 32'h5000;
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("t5_busy_start_ign", in_addr_o,       32'h1000);
    check("t5_no_restart",     32'(in_start_o), 32'd0);
    pulse_in_done();
    pulse_reducing();
    pulse_out_done();
    tick();
    pulse_in_done();
    pulse_reducing();
    check("t5_row1_div",  32'(dividing_o), 32'd1);
    check("t5_row1_idx",  32'(row_idx_o),  32'd1);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check("t5_clr_busy",    32'(busy_o),     32'd0);
    check("t5_clr_done",    32'(done_o),     32'd0);
    check("t5_clr_row_idx", 32'(row_idx_o),  32'd0);
    check("t5_clr_in_addr", in_addr_o,       32'd0);
    check("t5_clr_tot_len", tot_len_o,       32'd0);
    check("t5_clr_div",     32'(dividing_o), 32'd0);
    check("t5_clr_cycles",  cycles_o,        32'd0);
    pulse_out_done();
    check("t5_stray_done", 32'(done_o), 32'd0);
    check("t5_stray_busy", 32'(busy_o), 32'd0);

    // Asynchronous reset mid-batch
    n_rows_i = 16'd2;
    start_i = 1'b1; tick(); start_i = 1'b0;
    pulse_in_done();
    check("t6_pre_acc_fin", 32'(acc_finished_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_rst_busy",    32'(busy_o),         32'd0);
    check("t6_rst_acc_fin", 32'(acc_finished_o), 32'd0);
    check("t6_rst_in_addr", in_addr_o,           32'd0);
    check("t6_rst_tot_len", tot_len_o,           32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
